systolic_feeder: RTL and testbench

- Upstream stage of the weight-stationary systolic array.
- Loads one N_SIZE x N_SIZE weight tile into the array row by row, driving the array's wt_en / wt_row_sel / wt_serial.
- Then streams activation vectors into the array's row inputs, skewing element i by i cycles, and drains the skew pipeline with zeros.
- Sits between the on-chip tile buffers (valid/ready streams) and the systolic array.

---
 rtl/systolic_pkg.sv | 15 +
 rtl/systolic_feeder_skew_line.sv | 40 ++++
 rtl/systolic_feeder.sv | 197 +++++++++++++++++++
 tb/tb_systolic_feeder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and default sizing for the systolic-array feeder path.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } feeder_state_e;

  localparam int DEFAULT_DATAWIDTH = 8;
  localparam int DEFAULT_N_SIZE    = 32;
  localparam int DEFAULT_ROW_SEL_W = $clog2(DEFAULT_N_SIZE);

endpackage

// File: rtl/systolic_feeder_skew_line.sv
// One activation lane: its slice of the input register followed by DEPTH delay
// stages, each carrying data plus a valid bit. DEPTH=0 is the input register alone.
module skew_line
  import systolic_pkg::*;
#(
  parameter int DEPTH     = 0,
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATAWIDTH-1:0] din_i,
  input  logic                 vld_i,
  output logic [DATAWIDTH-1:0] dout_o,
  output logic                 vld_o
);

  logic [DATAWIDTH-1:0] dat_q [DEPTH+1];
  logic [DEPTH:0]       vld_q;

  // Shift chain: stage 0 takes the injected element, later stages follow.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= DEPTH; k++) begin
        dat_q[k] <= '0;
        vld_q[k] <= 1'b0;
      end
    end else begin
      dat_q[0] <= din_i;
      vld_q[0] <= vld_i;
      for (int k = 1; k <= DEPTH; k++) begin
        dat_q[k] <= dat_q[k-1];
        vld_q[k] <= vld_q[k-1];
      end
    end
  end

  assign dout_o = dat_q[DEPTH];
  assign vld_o  = vld_q[DEPTH];

endmodule

// File: rtl/systolic_feeder.sv
// Weight-tile loader and skewed activation streamer for the systolic array.
// Optional macro SYSTOLIC_FEEDER_STALL_CNT_EN adds the stall_cnt output.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH,
  parameter int N_SIZE    = DEFAULT_N_SIZE
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              reuse_wt,
  input  logic                              wt_valid,
  output logic                              wt_ready,
  input  logic [N_SIZE-1:0][DATAWIDTH-1:0]  wt_row_in,
  input  logic                              act_valid,
  output logic                              act_ready,
  input  logic                              act_last,
  input  logic [N_SIZE-1:0][DATAWIDTH-1:0]  act_vec,
  output logic                              wt_en,
  output logic [$clog2(N_SIZE)-1:0]         wt_row_sel,
  output logic [N_SIZE-1:0][DATAWIDTH-1:0]  wt_serial,
  output logic                              valid_in,
  output logic [N_SIZE-1:0][DATAWIDTH-1:0]  matrix_A,
  output logic                              busy,
  output logic                              tile_done
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
  ,
  output logic [31:0]                       stall_cnt
`endif
);

  localparam int ROW_SEL_W = $clog2(N_SIZE);
  localparam logic [ROW_SEL_W-1:0] LAST_IDX = ROW_SEL_W'(N_SIZE - 1);

  feeder_state_e state_q, state_d;
  logic [ROW_SEL_W-1:0] row_cnt_q, row_cnt_d;
  logic [ROW_SEL_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [ROW_SEL_W-1:0] wt_row_sel_q, wt_row_sel_d;
  logic [N_SIZE-1:0][DATAWIDTH-1:0] wt_serial_q, wt_serial_d;
  logic wt_en_q, wt_en_d;
  logic tile_done_q, tile_done_d;
  logic valid_in_q, valid_in_d;
  logic wt_ready_q, act_ready_q, busy_q;
  logic wt_fire_s, act_fire_s;
  logic [N_SIZE-1:0][DATAWIDTH-1:0] inj_dat_s, lane_dat_s;
  logic [N_SIZE-1:0] lane_vld_s;

  // Sequencing of the tile plus the weight-port output values.
  always_comb begin
    state_d      = state_q;
    row_cnt_d    = row_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    wt_en_d      = 1'b0;
    wt_row_sel_d = wt_row_sel_q;
    wt_serial_d  = wt_serial_q;
    tile_done_d  = 1'b0;
    wt_fire_s    = wt_valid & wt_ready_q;
    act_fire_s   = act_valid & act_ready_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (reuse_wt) begin
            state_d = STREAM;
          end else begin
            state_d   = LOAD_W;
            row_cnt_d = '0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD_W: begin
        if (wt_fire_s) begin
          wt_en_d      = 1'b1;
          wt_row_sel_d = row_cnt_q;
          wt_serial_d  = wt_row_in;
          row_cnt_d    = row_cnt_q + ROW_SEL_W'(1);
          if (row_cnt_q == LAST_IDX) begin
            state_d = STREAM;
          end else begin
            state_d = LOAD_W;
          end
        end else begin
          state_d = LOAD_W;
        end
      end
      STREAM: begin
        if (act_fire_s && act_last) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end else begin
          state_d = STREAM;
        end
      end
      DRAIN: begin
        if (drain_cnt_q == LAST_IDX) begin
          state_d     = IDLE;
          tile_done_d = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + ROW_SEL_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Lane i+1 next cycle sees what lane i holds now, so valid_in can be registered.
  always_comb begin
    inj_dat_s  = act_fire_s ? act_vec : '0;
    valid_in_d = act_fire_s | (|lane_vld_s[N_SIZE-2:0]);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      row_cnt_q    <= '0;
      drain_cnt_q  <= '0;
      wt_en_q      <= 1'b0;
      wt_row_sel_q <= '0;
      wt_serial_q  <= '0;
      tile_done_q  <= 1'b0;
      valid_in_q   <= 1'b0;
      wt_ready_q   <= 1'b0;
      act_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_cnt_q    <= row_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      wt_en_q      <= wt_en_d;
      wt_row_sel_q <= wt_row_sel_d;
      wt_serial_q  <= wt_serial_d;
      tile_done_q  <= tile_done_d;
      valid_in_q   <= valid_in_d;
      wt_ready_q   <= (state_d == LOAD_W);
      act_ready_q  <= (state_d == STREAM);
      busy_q       <= (state_d != IDLE);
    end
  end

  for (genvar i = 0; i < N_SIZE; i++) begin : g_lane
    skew_line #(
      .DEPTH     (i),
      .DATAWIDTH (DATAWIDTH)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .din_i  (inj_dat_s[i]),
      .vld_i  (act_fire_s),
      .dout_o (lane_dat_s[i]),
      .vld_o  (lane_vld_s[i])
    );
    assign matrix_A[i] = lane_vld_s[i] ? lane_dat_s[i] : '0;
  end

  assign wt_ready   = wt_ready_q;
  assign act_ready  = act_ready_q;
  assign wt_en      = wt_en_q;
  assign wt_row_sel = wt_row_sel_q;
  assign wt_serial  = wt_serial_q;
  assign valid_in   = valid_in_q;
  assign busy       = busy_q;
  assign tile_done  = tile_done_q;

`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        stall_s;

  // Ready-without-valid cycles, restarted by every accepted tile start.
  always_comb begin
    stall_s = (wt_ready_q & ~wt_valid) | (act_ready_q & ~act_valid);
    if ((state_q == IDLE) && start) begin
      stall_cnt_d = '0;
    end else if (stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed table-driven bench for systolic_feeder at N_SIZE=4, DATAWIDTH=8.
module tb_systolic_feeder;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam logic [31:0] Z = 32'h0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, reuse_wt, wt_valid, act_valid, act_last;
  logic [N-1:0][DW-1:0] wt_row_in, act_vec, wt_serial, matrix_A;
  logic wt_ready, act_ready, wt_en, valid_in, busy, tile_done;
  logic [1:0] wt_row_sel;
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  systolic_feeder #(.DATAWIDTH(DW), .N_SIZE(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .reuse_wt   (reuse_wt),
    .wt_valid   (wt_valid),
    .wt_ready   (wt_ready),
    .wt_row_in  (wt_row_in),
    .act_valid  (act_valid),
    .act_ready  (act_ready),
    .act_last   (act_last),
    .act_vec    (act_vec),
    .wt_en      (wt_en),
    .wt_row_sel (wt_row_sel),
    .wt_serial  (wt_serial),
    .valid_in   (valid_in),
    .matrix_A   (matrix_A),
    .busy       (busy),
    .tile_done  (tile_done)
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  typedef struct {
    logic        start;
    logic        reuse;
    logic        wv;
    logic [31:0] wrow;
    logic        av;
    logic        al;
    logic [31:0] avec;
    logic        e_en;
    logic [1:0]  e_sel;
    logic [31:0] e_ser;
    logic        e_vin;
    logic [31:0] e_ma;
    logic        e_busy;
    logic        e_done;
    logic        e_wrdy;
    logic        e_ardy;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  function automatic logic [31:0] v4(input logic [7:0] a, input logic [7:0] b,
                                     input logic [7:0] c, input logic [7:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [31:0] row4(input logic [7:0] r);
    return v4(r, r + 8'd1, r + 8'd2, r + 8'd3);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    start = 1'b0; reuse_wt = 1'b0; wt_valid = 1'b0; wt_row_in = '0;
    act_valid = 1'b0; act_last = 1'b0; act_vec = '0;
  endtask

  task automatic apply_row(input vec_t v, input int idx);
    start = v.start; reuse_wt = v.reuse; wt_valid = v.wv; wt_row_in = v.wrow;
    act_valid = v.av; act_last = v.al; act_vec = v.avec;
    tick();
    chk($sformatf("row%0d.wt_en", idx), wt_en, v.e_en);
    chk($sformatf("row%0d.wt_row_sel", idx), wt_row_sel, v.e_sel);
    chk($sformatf("row%0d.wt_serial", idx), wt_serial, v.e_ser);
    chk($sformatf("row%0d.valid_in", idx), valid_in, v.e_vin);
    chk($sformatf("row%0d.matrix_A", idx), matrix_A, v.e_ma);
    chk($sformatf("row%0d.busy", idx), busy, v.e_busy);
    chk($sformatf("row%0d.tile_done", idx), tile_done, v.e_done);
    chk($sformatf("row%0d.wt_ready", idx), wt_ready, v.e_wrdy);
    chk($sformatf("row%0d.act_ready", idx), act_ready, v.e_ardy);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r0, r10, r20, r30, wrow, last_ser;
    logic [1:0]  last_sel;
    logic        saw_done;
    int          seen;

    r0 = row4(8'd0); r10 = row4(8'd10); r20 = row4(8'd20); r30 = row4(8'd30);
    // st    rs    wv    wrow av    al    avec              | en    sel   ser  vin   matrix_A          busy  done  wrdy  ardy
    tbl.push_back('{1'b1, 1'b0, 1'b0, Z,   1'b0, 1'b0, Z,                1'b0, 2'd0, Z,   1'b0, Z,                1'b1, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, r0,  1'b0, 1'b0, Z,                1'b1, 2'd0, r0,  1'b0, Z,                1'b1, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, r10, 1'b0, 1'b0, Z,                1'b1, 2'd1, r10, 1'b0, Z,                1'b1, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, r20, 1'b0, 1'b0, Z,                1'b1, 2'd2, r20, 1'b0, Z,                1'b1, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, r30, 1'b0, 1'b0, Z,                1'b1, 2'd3, r30, 1'b0, Z,                1'b1, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, Z,   1'b1, 1'b1, v4(1,2,3,4),      1'b0, 2'd3, r30, 1'b1, v4(1,0,0,0),      1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, Z,   1'b0, 1'b0, Z,                1'b0, 2'd3, r30, 1'b1, v4(0,2,0,0),      1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, Z,   1'b0, 1'b0, Z,                1'b0, 2'd3, r30, 1'b1, v4(0,0,3,0),      1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, Z,   1'b0, 1'b0, Z,                1'b0, 2'd3, r30, 1'b1, v4(0,0,0,4),      1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, Z,   1'b0, 1'b0, Z,                1'b0, 2'd3, r30, 1'b0, Z,                1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, Z,   1'b0, 1'b0, Z,                1'b0, 2'd3, r30, 1'b0, Z,                1'b1, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 1'b0, Z,   1'b1, 1'b0, v4(5,5,5,5),      1'b0, 2'd3, r30, 1'b1, v4(5,0,0,0),      1'b1, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, Z,   1'b0, 1'b0, Z,                1'b0, 2'd3, r30, 1'b1, v4(0,5,0,0),      1'b1, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, Z,   1'b1, 1'b1, v4(6,6,6,6),      1'b0, 2'd3, r30, 1'b1, v4(6,0,5,0),      1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, Z,   1'b0, 1'b0, Z,                1'b0, 2'd3, r30, 1'b1, v4(0,6,0,5),      1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, Z,   1'b0, 1'b0, Z,                1'b0, 2'd3, r30, 1'b1, v4(0,0,6,0),      1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, Z,   1'b0, 1'b0, Z,                1'b0, 2'd3, r30, 1'b1, v4(0,0,0,6),      1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, Z,   1'b0, 1'b0, Z,                1'b0, 2'd3, r30, 1'b0, Z,                1'b0, 1'b1, 1'b0, 1'b0});

    // Reset state
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    chk("reset.wt_en", wt_en, 1'b0);
    chk("reset.wt_row_sel", wt_row_sel, 2'd0);
    chk("reset.wt_serial", wt_serial, Z);
    chk("reset.valid_in", valid_in, 1'b0);
    chk("reset.matrix_A", matrix_A, Z);
    chk("reset.busy", busy, 1'b0);
    chk("reset.tile_done", tile_done, 1'b0);
    chk("reset.wt_ready", wt_ready, 1'b0);
    chk("reset.act_ready", act_ready, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      apply_row(tbl[i], i);
    end
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
    chk("bubble.stall_cnt", stall_cnt, 32'd1);
`endif

    // Reset during DRAIN aborts the tile with no completion pulse
    idle_inputs();
    start = 1'b1; reuse_wt = 1'b1;
    tick();
    idle_inputs();
    act_valid = 1'b1; act_last = 1'b1; act_vec = v4(7, 8, 9, 10);
    tick();
    idle_inputs();
    chk("abort.lane0", matrix_A, v4(7, 0, 0, 0));
    tick();
    chk("abort.lane1", matrix_A, v4(0, 8, 0, 0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort.busy", busy, 1'b0);
    chk("abort.valid_in", valid_in, 1'b0);
    chk("abort.matrix_A", matrix_A, Z);
    chk("abort.tile_done", tile_done, 1'b0);
    chk("abort.act_ready", act_ready, 1'b0);
    saw_done = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      saw_done = saw_done | tile_done | (|matrix_A);
    end
    chk("abort.quiet_after", saw_done, 1'b0);

    // Weight backpressure: wt_valid toggling 1,0,1,0...
    start = 1'b1; reuse_wt = 1'b0;
    tick();
    idle_inputs();
    chk("bp.wt_ready", wt_ready, 1'b1);
    last_ser = Z;
    last_sel = 2'd0;
    for (int k = 0; k < 7; k++) begin
      wrow = row4(8'(40 + 4 * k));
      wt_valid = (k % 2 == 0);
      wt_row_in = wrow;
      tick();
      if (k % 2 == 0) begin
        last_ser = wrow;
        last_sel = 2'(k / 2);
      end
      chk($sformatf("bp%0d.wt_en", k), wt_en, (k % 2 == 0));
      chk($sformatf("bp%0d.wt_row_sel", k), wt_row_sel, last_sel);
      chk($sformatf("bp%0d.wt_serial", k), wt_serial, last_ser);
    end
    idle_inputs();
    chk("bp.act_ready", act_ready, 1'b1);
    chk("bp.wt_ready_off", wt_ready, 1'b0);
    tick();
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
    chk("bp.stall_cnt", stall_cnt, 32'd4);
`endif
    act_valid = 1'b1; act_last = 1'b1; act_vec = v4(11, 12, 13, 14);
    tick();
    idle_inputs();
    chk("bp.lane0", matrix_A, v4(11, 0, 0, 0));
    seen = 0;
    for (int c = 1; c <= 12; c++) begin
      if (tile_done) begin
        seen = c;
        break;
      end
      tick();
    end
    chk("bp.tile_done_latency", seen, N + 1);
    chk("bp.busy_at_done", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
